// File: rtl/servo_pwm_gen_if.sv
// Servo PWM generator port bundle: commanded angle/enable in, PWM line and status out.
// Latency: n/a (signal grouping only).
// Backpressure: none; the generator samples inputs every cycle and never stalls.
interface servo_pwm_gen_if;
  logic [7:0] pos;
  logic       en;
  logic       pwm;
  logic       frame_start;
  logic [7:0] pos_active;

  modport master (
    output pos, en,
    input  pwm, frame_start, pos_active
  );

  modport slave (
    input  pos, en,
    output pwm, frame_start, pos_active
  );
endinterface

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM generator: fixed frame, pulse width linear in clamped angle.
// Latency: angle reaches the line within FRAME_CYCLES+2 clocks; width pipe is one stage.
// Backpressure: none; pos/en are only committed at frame boundaries, never mid-pulse.
module servo_pwm_gen #(
  parameter int CLK_HZ        = 50_000_000,
  parameter int FRAME_CYCLES  = 1_000_000,
  parameter int MIN_PULSE     = 25_000,
  parameter int TICKS_PER_DEG = 556,
  parameter int MAX_DEG       = 180
) (
  input  logic            clk,
  input  logic            rst,
  servo_pwm_gen_if.slave  bus
);

  localparam int CW = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] MIN_W    = CW'(MIN_PULSE);
  localparam logic [CW-1:0] TICKS_W  = CW'(TICKS_PER_DEG);
  localparam logic [7:0]    MAX_POS  = 8'(MAX_DEG);

  // The longest pulse must end strictly inside the frame, or the line would never fall.
  if (CLK_HZ <= 0 || MIN_PULSE < 1 ||
      MIN_PULSE + MAX_DEG * TICKS_PER_DEG >= FRAME_CYCLES) begin : g_bad_params
    $error("servo_pwm_gen: illegal timing parameters");
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] width_pipe_q, width_pipe_d;
  logic [7:0]    pos_pipe_q, pos_pipe_d;
  logic [CW-1:0] width_q, width_d;
  logic          en_q, en_d;
  logic          pwm_q, pwm_d;
  logic [7:0]    pos_active_q, pos_active_d;
  logic [7:0]    pos_c;
  logic          boundary;

  // Clamp angle, then compute next-state for counter, width pipe and frame-latched values.
  always_comb begin
    pos_c        = (bus.pos > MAX_POS) ? MAX_POS : bus.pos;
    boundary     = (cnt_q == LAST_CNT);
    cnt_d        = boundary ? '0 : cnt_q + CW'(1);
    width_pipe_d = MIN_W + CW'(pos_c) * TICKS_W;
    pos_pipe_d   = pos_c;
    width_d      = width_q;
    en_d         = en_q;
    pos_active_d = pos_active_q;
    pwm_d        = pwm_q;
    if (boundary) begin
      // Everything that shapes the next frame is committed together here.
      width_d      = width_pipe_q;
      en_d         = bus.en;
      pos_active_d = pos_pipe_q;
      pwm_d        = bus.en;
    end else if (!en_q || cnt_d == width_q) begin
      // Falling edge lands as cnt enters width_q, giving exactly width_q high cycles.
      pwm_d = 1'b0;
    end
  end

  // State registers; reset drops the line at once and restarts the frame from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '0;
      width_pipe_q <= MIN_W;
      pos_pipe_q   <= '0;
      width_q      <= MIN_W;
      en_q         <= 1'b0;
      pwm_q        <= 1'b0;
      pos_active_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      width_pipe_q <= width_pipe_d;
      pos_pipe_q   <= pos_pipe_d;
      width_q      <= width_d;
      en_q         <= en_d;
      pwm_q        <= pwm_d;
      pos_active_q <= pos_active_d;
    end
  end

  // Decoded from the counter so the strobe covers the cnt=0 cycle right after reset release.
  assign bus.frame_start = rst && (cnt_q == '0);
  assign bus.pwm         = pwm_q;
  assign bus.pos_active  = pos_active_q;

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Bench for servo_pwm_gen: directed per-frame vectors, frame monitor with scoreboard.
// Latency: expected frame pushed one frame ahead of the frame it describes.
// Backpressure: none; monitor measures every frame delimited by frame_start.
module tb_servo_pwm_gen;

  localparam int FRAME = 2000;
  localparam int MINP  = 50;
  localparam int TPD   = 5;
  localparam int MAXD  = 180;

  logic clk;
  logic rst;
  servo_pwm_gen_if bus();

  servo_pwm_gen #(
    .CLK_HZ(50_000_000), .FRAME_CYCLES(FRAME), .MIN_PULSE(MINP),
    .TICKS_PER_DEG(TPD), .MAX_DEG(MAXD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int width;
    int pa;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  // monitor state
  int len, hi, lead, pa;
  bit in_frame, seen_low;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int p, input bit e);
    exp_t x;
    x.pa    = (p > MAXD) ? MAXD : p;
    x.width = e ? (MINP + TPD * x.pa) : 0;
    sb.push_back(x);
  endtask

  task automatic finish_frame();
    exp_t x;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL frame_unexpected: got width %0d, expected no frame (t=%0t)", hi, $time);
    end else begin
      x = sb.pop_front();
      check("period", len, FRAME);
      check("width", hi, x.width);
      check("shape", lead, hi);
      check("pos_active", pa, x.pa);
    end
  endtask

  // Monitor: measure each frame between frame_start strobes, compare against scoreboard.
  initial begin
    in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_frame = 1'b0;
      end else begin
        if (bus.frame_start) begin
          if (in_frame) finish_frame();
          in_frame = 1'b1;
          len = 0; hi = 0; lead = 0; seen_low = 1'b0;
          pa = int'(bus.pos_active);
        end
        if (in_frame) begin
          len++;
          if (bus.pwm) begin
            hi++;
            if (!seen_low) lead++;
          end else begin
            seen_low = 1'b1;
          end
        end
      end
    end
  end

  task automatic wait_fs();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME + 10; i++) begin
      @(negedge clk);
      if (bus.frame_start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check("frame_start_timeout", 0, 1);
  endtask

  // Wait for the next frame, move n cycles in, apply pos/en, record next frame's expectation.
  task automatic mid_change(input int n, input int p, input bit e);
    wait_fs();
    repeat (n) @(negedge clk);
    bus.pos = 8'(p);
    bus.en  = e;
    push_exp(p, e);
  endtask

  initial begin
    rst     = 1'b0;
    bus.pos = 8'd90;
    bus.en  = 1'b1;

    // reset state
    #1;
    check("rst_pwm", int'(bus.pwm), 0);
    check("rst_frame_start", int'(bus.frame_start), 0);
    check("rst_pos_active", int'(bus.pos_active), 0);
    repeat (5) @(posedge clk);
    #1;
    check("rst_hold_pwm", int'(bus.pwm), 0);
    check("rst_hold_frame_start", int'(bus.frame_start), 0);
    check("rst_hold_pos_active", int'(bus.pos_active), 0);
    push_exp(0, 1'b0);            // first frame after release is silent
    #1 rst = 1'b1;

    mid_change(0, 90, 1'b1);      // 500
    mid_change(0, 0, 1'b1);       // 50
    mid_change(0, 180, 1'b1);     // 950
    mid_change(0, 255, 1'b1);     // clamps to 950 / 180
    mid_change(0, 90, 1'b1);      // 500
    mid_change(100, 10, 1'b1);    // during 500 pulse; next 100
    mid_change(1998, 30, 1'b1);   // last legal cycle; next 200
    mid_change(0, 90, 1'b1);      // 500
    mid_change(300, 90, 1'b0);    // en drop mid-pulse; next silent
    mid_change(0, 45, 1'b0);      // still silent, pos_active 45
    mid_change(0, 90, 1'b1);      // pos and en together; next 500

    // async reset in the middle of a 500-cycle pulse
    wait_fs();
    repeat (200) @(negedge clk);
    check("pwm_before_rst", int'(bus.pwm), 1);
    #1 rst = 1'b0;
    sb.delete();
    #1;
    check("async_rst_pwm", int'(bus.pwm), 0);
    check("async_rst_frame_start", int'(bus.frame_start), 0);
    check("async_rst_pos_active", int'(bus.pos_active), 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    push_exp(0, 1'b0);
    mid_change(0, 90, 1'b1);

    // ramp across both ends of the range, including the clamp point
    for (int p = 0; p < 8; p++) mid_change(0, p, 1'b1);
    for (int p = 176; p < 184; p++) mid_change(0, p, 1'b1);

    for (int i = 0; i < 3 * FRAME; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) check("scoreboard_drain", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
